// File: rtl/mag_sweep.sv
// Drives the three inputs of a 3-input combinational block through all eight vectors.
// After each vector settles it samples F, and at the end of the sweep it reports the truth table and the ones count.
module mag_sweep #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth,
    output logic [3:0] ones_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] idx_reg, idx_next;
    logic [2:0] vec_reg, vec_next;
    logic [7:0] settle_cnt_reg, settle_cnt_next;
    logic [7:0] truth_reg, truth_next;
    logic [3:0] ones_reg, ones_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       sample_point;
    logic       clear_result;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        vec_next        = vec_reg;
        settle_cnt_next = settle_cnt_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        sample_point    = 1'b0;
        clear_result    = 1'b0;

        case (state_reg)
            IDLE: begin
                vec_next  = 3'd0;
                busy_next = 1'b0;
                done_next = 1'b0;
                if (start) begin
                    state_next      = SETTLE;
                    idx_next        = 3'd0;
                    settle_cnt_next = 8'd0;
                    busy_next       = 1'b1;
                    clear_result    = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == LAST_CNT) begin
                    sample_point = 1'b1;
                    if (idx_reg != 3'd7) begin
                        idx_next        = idx_reg + 3'd1;
                        vec_next        = idx_reg + 3'd1;
                        settle_cnt_next = 8'd0;
                    end else begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        vec_next   = 3'd0;
                    end
                end else begin
                    settle_cnt_next = settle_cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b0;
                busy_next  = 1'b0;
                vec_next   = 3'd0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b0;
                vec_next   = 3'd0;
            end
        endcase

        if (clear_result)
            ones_next = 4'd0;
        else if (sample_point)
            ones_next = ones_reg + {3'd0, f_in};
        else
            ones_next = ones_reg;
    end

    // Each truth bit only listens to f_in while its own vector is at its sample point.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_truth
            assign truth_next[gi] = clear_result ? 1'b0 :
                                    (sample_point && idx_reg == 3'(gi)) ? f_in :
                                    truth_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            vec_reg        <= 3'd0;
            settle_cnt_reg <= 8'd0;
            truth_reg      <= 8'h00;
            ones_reg       <= 4'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            vec_reg        <= vec_next;
            settle_cnt_reg <= settle_cnt_next;
            truth_reg      <= truth_next;
            ones_reg       <= ones_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign a          = vec_reg[2];
    assign b          = vec_reg[1];
    assign c          = vec_reg[0];
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign truth      = truth_reg;
    assign ones_count = ones_reg;

endmodule

// File: tb/tb_mag_sweep.sv
// Bench for mag_sweep: three instances (settle 4, 1, 2) checked every cycle against a time-based sweep model.
// Directed scenarios add literal checks on the final truth words, the ones counts and the busy/done cycle counts.
module tb_mag_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, f_v, a_v, b_v, c_v, busy_v, done_v;
    logic [7:0] truth_v [3];
    logic [3:0] ones_v [3];
    int         mode [3];

    int tests = 0;
    int fails = 0;
    int busy_cnt [3];
    int done_cnt [3];

    localparam int S_TAB [3] = '{4, 1, 2};

    // mode 0: F = a, 1: majority, 2: constant 0, 3: constant 1
    function automatic logic f_of(int m, logic [2:0] v);
        case (m)
            0:       return v[2];
            1:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign f_v[0] = f_of(mode[0], {a_v[0], b_v[0], c_v[0]});
    assign f_v[1] = f_of(mode[1], {a_v[1], b_v[1], c_v[1]});
    assign f_v[2] = f_of(mode[2], {a_v[2], b_v[2], c_v[2]});

    mag_sweep #(.SETTLE_CYCLES(4)) u_s4 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .f_in(f_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .truth(truth_v[0]), .ones_count(ones_v[0])
    );
    mag_sweep #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .f_in(f_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .truth(truth_v[1]), .ones_count(ones_v[1])
    );
    mag_sweep #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .f_in(f_v[2]),
        .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .truth(truth_v[2]), .ones_count(ones_v[2])
    );

    // Model: a sweep is "n cycles since the accepted start"; vector n/S is shown,
    // vector v is captured when n reaches (v+1)*S, done follows n == 8*S.
    bit         m_active [3];
    bit         m_done [3];
    int         m_n [3];
    logic [7:0] m_truth [3];
    int         m_ones [3];

    task automatic chk(input string name, input int j, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[inst %0d] t=%0t got %0h expected %0h", name, j, $time, act, exp);
        end
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            m_active[j] = 0; m_done[j] = 0; m_n[j] = 0; m_truth[j] = 8'h00; m_ones[j] = 0;
        end
        forever begin
            @(posedge clk);
            for (int j = 0; j < 3; j++) begin
                if (rst_v[j]) begin
                    m_active[j] = 0; m_done[j] = 0; m_n[j] = 0; m_truth[j] = 8'h00; m_ones[j] = 0;
                end else if (m_done[j]) begin
                    m_done[j] = 0;
                end else if (m_active[j]) begin
                    m_n[j]++;
                    if (m_n[j] % S_TAB[j] == 0) begin
                        int   v;
                        logic fv;
                        v  = m_n[j] / S_TAB[j] - 1;
                        fv = f_of(mode[j], 3'(v));
                        m_truth[j][v] = fv;
                        m_ones[j] += int'(fv);
                    end
                    if (m_n[j] == 8 * S_TAB[j]) begin
                        m_active[j] = 0;
                        m_done[j]   = 1;
                    end
                end else if (start_v[j]) begin
                    m_active[j] = 1; m_n[j] = 0; m_truth[j] = 8'h00; m_ones[j] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                logic [2:0] ev;
                ev = m_active[j] ? 3'(m_n[j] / S_TAB[j]) : 3'd0;
                chk("abc", j, {5'd0, a_v[j], b_v[j], c_v[j]}, {5'd0, ev});
                chk("busy", j, {7'd0, busy_v[j]}, {7'd0, m_active[j]});
                chk("done", j, {7'd0, done_v[j]}, {7'd0, m_done[j]});
                chk("truth", j, truth_v[j], m_truth[j]);
                chk("ones", j, {4'd0, ones_v[j]}, 8'(m_ones[j]));
                busy_cnt[j] += int'(busy_v[j]);
                done_cnt[j] += int'(done_v[j]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int j);
        start_v[j] = 1'b1;
        @(negedge clk);
        start_v[j] = 1'b0;
    endtask

    task automatic wait_done(input int j);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_v[j]) break;
        end
        chk("done_seen", j, {7'd0, done_v[j]}, 8'd1);
    endtask

    initial begin
        rst_v = 3'b111; start_v = 3'b000;
        for (int j = 0; j < 3; j++) begin mode[j] = 0; busy_cnt[j] = 0; done_cnt[j] = 0; end
        step(3);
        chk("rst_truth", 0, truth_v[0], 8'h00);
        chk("rst_ones", 0, {4'd0, ones_v[0]}, 8'd0);
        chk("rst_busy", 1, {7'd0, busy_v[1]}, 8'd0);
        rst_v = 3'b000;
        step(1);

        // F = a, settle 4
        mode[0] = 0; busy_cnt[0] = 0;
        pulse(0);
        wait_done(0);
        chk("t1_truth", 0, truth_v[0], 8'hF0);
        chk("t1_ones", 0, {4'd0, ones_v[0]}, 8'd4);
        chk("t1_busy_cycles", 0, 8'(busy_cnt[0]), 8'd32);
        step(1);
        chk("t1_done_one_cycle", 0, {7'd0, done_v[0]}, 8'd0);
        $display("[TB] sweep1 F=a truth=%h ones=%0d", truth_v[0], ones_v[0]);

        // majority, then constant 0
        mode[0] = 1;
        pulse(0);
        wait_done(0);
        chk("t2_truth", 0, truth_v[0], 8'hE8);
        chk("t2_ones", 0, {4'd0, ones_v[0]}, 8'd4);
        $display("[TB] sweep2 majority truth=%h ones=%0d", truth_v[0], ones_v[0]);
        step(3);
        mode[0] = 2;
        chk("t2_hold", 0, truth_v[0], 8'hE8);
        pulse(0);
        wait_done(0);
        chk("t2b_truth", 0, truth_v[0], 8'h00);
        chk("t2b_ones", 0, {4'd0, ones_v[0]}, 8'd0);
        $display("[TB] sweep3 zero truth=%h ones=%0d", truth_v[0], ones_v[0]);

        // settle 1, F = 1
        mode[1] = 3; busy_cnt[1] = 0;
        pulse(1);
        wait_done(1);
        chk("t3_truth", 1, truth_v[1], 8'hFF);
        chk("t3_ones", 1, {4'd0, ones_v[1]}, 8'd8);
        chk("t3_busy_cycles", 1, 8'(busy_cnt[1]), 8'd8);
        $display("[TB] sweep4 settle1 truth=%h ones=%0d", truth_v[1], ones_v[1]);

        // start re-pulsed mid-sweep is ignored
        step(2);
        mode[0] = 1; done_cnt[0] = 0;
        pulse(0);
        step(4);
        pulse(0);
        step(14);
        pulse(0);
        wait_done(0);
        chk("t4_truth", 0, truth_v[0], 8'hE8);
        step(1);
        chk("t4_single_done", 0, 8'(done_cnt[0]), 8'd1);
        $display("[TB] sweep5 repulse truth=%h dones=%0d", truth_v[0], done_cnt[0]);

        // reset mid-sweep
        step(2);
        mode[0] = 0; done_cnt[0] = 0;
        pulse(0);
        step(9);
        rst_v[0] = 1'b1;
        step(1);
        rst_v[0] = 1'b0;
        chk("t5_busy", 0, {7'd0, busy_v[0]}, 8'd0);
        chk("t5_truth", 0, truth_v[0], 8'h00);
        chk("t5_ones", 0, {4'd0, ones_v[0]}, 8'd0);
        step(40);
        chk("t5_no_done", 0, 8'(done_cnt[0]), 8'd0);
        pulse(0);
        wait_done(0);
        chk("t5_after_truth", 0, truth_v[0], 8'hF0);
        $display("[TB] sweep6 after reset truth=%h ones=%0d", truth_v[0], ones_v[0]);

        // start held high, settle 2
        mode[2] = 0; done_cnt[2] = 0; busy_cnt[2] = 0;
        start_v[2] = 1'b1;
        step(100);
        start_v[2] = 1'b0;
        step(30);
        chk("t6_done_pulses", 2, 8'(done_cnt[2]), 8'd6);
        chk("t6_busy_cycles", 2, 8'(busy_cnt[2]), 8'd96);
        chk("t6_truth", 2, truth_v[2], 8'hF0);
        $display("[TB] held-start sweeps=%0d busy_cycles=%0d", done_cnt[2], busy_cnt[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
